block_ram_responder: RTL
========================

Name: block_ram_responder

Overview:
- Memory-side responder for the cache miss/propagation interface.
- Accepts the cache's prop_* read and write requests and returns whole blocks on ram_valid/ram_data after a programmable latency.
- Applies single-word writes to a word-addressed backing array.
- Sits between the cache and the simulation/FPGA top; it is the backing store for every cache bench.

Parameters:
- RAM_ADDRESS_BITS, 10, word address width; array depth 2**RAM_ADDRESS_BITS.
- DATA_BITS, 32, word width.
- BLOCK_BITS, 2, log2 words per block; BLOCK_SIZE = 2**BLOCK_BITS.
- READ_LATENCY, 4, cycles from read acceptance to ram_valid; legal range 1..255.

Ports:
- clk, input, 1, clock; all logic on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, RAM_ADDRESS_BITS, word address (cache prop_address).
- read_en, input, 1, block read request (cache prop_read_en), level-held until served.
- write_data, input, DATA_BITS, word to write (cache prop_write_data).
- write_en, input, 1, single-word write strobe (cache prop_write_en).
- ram_valid, output, 1, one-cycle pulse; ram_data is valid this cycle.
- ram_data, output, DATA_BITS x BLOCK_SIZE (unpacked [BLOCK_SIZE-1:0]), block words, element k = word at block base + k.
- busy, output, 1, high in WAIT and RESP.

Behaviour:
- Reset (async assert, sync release): state IDLE; ram_valid=0; ram_data all '0; busy=0; latency counter 0; armed=1. The array is not reset.
- Array initial content at time zero: mem[i] = i, zero-extended to DATA_BITS.
- Block base = address with the low BLOCK_BITS cleared; the offset is ignored for reads.
- FSM IDLE:
  - read_en & armed → latch block base, load counter READ_LATENCY-1, go to WAIT (busy=1).
  - Otherwise stay in IDLE.
- FSM WAIT:
  - Counter decrements each cycle.
  - At 0, sample the BLOCK_SIZE words from the array into the ram_data register and go to RESP.
- FSM RESP:
  - ram_valid=1 for exactly this cycle.
  - Record served block base; armed=0; go to IDLE.
- Total latency: read accepted at edge N → ram_valid high in cycle N+READ_LATENCY.
- ram_data holds its last value after RESP until the next response.
- Re-arm rule: armed returns to 1 on the first cycle in IDLE where read_en=0 or the address block base differs from the served base. This prevents re-serving the cache's still-held request after ram_valid.
- read_en dropping during WAIT does not abort the read; the response is still issued.
- Writes:
  - write_en high in any state → mem[address] <= write_data at that edge (full address, offset included).
  - Writes never stall and have no acknowledgment.
- Write during WAIT to the pending block is visible in the response if it occurs at or before the sampling edge.
- write_en and read_en together in IDLE: the write is applied at that edge and the read is accepted at the same edge; the response contains the new word.
- Address is X-free when read_en or write_en is high; the behaviour is otherwise undefined.

Optional Feature:
- Macro: RAM_LFSR_LATENCY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'h01) advances on every read acceptance.
  - Its two LSBs (0..3) are added to the load value, so latency = READ_LATENCY + lfsr[1:0].
  - This stresses the cache stall path.
- When undefined: latency is fixed at READ_LATENCY and no LFSR logic exists.

Decomposition:
- cache_pkg holds:
  - BLOCK_SIZE computation.
  - ram_state_t enum {IDLE, WAIT, RESP}.
  - LFSR seed/tap constants.
  - Shared with the cache for typing ram_data.
- One sub-module, ram_latency_timer:
  - Handles counter load/decrement and done flag.
  - Contains the LFSR under RAM_LFSR_LATENCY_EN.

Test Plan:
- Reset: assert reset_n=0 mid-WAIT → ram_valid=0, busy=0, ram_data all 0 immediately; after release, read of addr 0x000 returns {3,2,1,0} at +4 cycles.
- Basic read: read_en=1, address=0x016 held → ram_valid pulses once at cycle +4, ram_data={0x17,0x16,0x15,0x14}. No second pulse while the request is held.
- Re-arm: hold 0x016 through the response, then switch to 0x020 without dropping read_en → second response {0x23,0x22,0x21,0x20}. Drop and reassert for 0x016 → served again.
- Write then read: write_en, address=0x015, data=0xDEADBEEF → later read of 0x014 returns element 1 = 0xDEADBEEF.
- Write during WAIT: read of 0x040 accepted, write 0x042=0xA5A5A5A5 two cycles later → response element 2 = 0xA5A5A5A5.
- RAM_LFSR_LATENCY_EN: issue 8 back-to-back reads → latencies match a reference LFSR model (4..7 cycles); each response has the correct data and exactly one ram_valid pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache and its memory-side responder.
// The LFSR constants are used only when RAM_LFSR_LATENCY_EN is defined.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ram_state_t;

  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int block_size(input int block_bits);
    return 1 << block_bits;
  endfunction

endpackage

// File: rtl/block_ram_responder_timer.sv
// Read-latency down-counter for the block RAM responder.
// With RAM_LFSR_LATENCY_EN defined, an LFSR adds 0..3 cycles to each read.
module ram_latency_timer
  import cache_pkg::*;
#(
  parameter int READ_LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CW = 9;

  logic [CW-1:0] cnt_q, cnt_d, load_val;

`ifdef RAM_LFSR_LATENCY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // The pre-advance value sets this read's extra latency
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign load_val = CW'(READ_LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
  assign load_val = CW'(READ_LATENCY - 1);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/block_ram_responder.sv
// Memory-side responder: serves whole-block reads after a programmable latency
// and applies single-word writes. Optional random extra latency: RAM_LFSR_LATENCY_EN.
module block_ram_responder
  import cache_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  parameter int READ_LATENCY     = 4,
  localparam int BLOCK_SIZE      = block_size(BLOCK_BITS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic                        read_en,
  input  logic [DATA_BITS-1:0]        write_data,
  input  logic                        write_en,
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [BLOCK_SIZE-1:0],
  output logic                        busy,
  output ram_state_t                  ram_state
);

  localparam int DEPTH = 1 << RAM_ADDRESS_BITS;
  localparam logic [RAM_ADDRESS_BITS-1:0] OFF_MASK = RAM_ADDRESS_BITS'(BLOCK_SIZE - 1);

  typedef logic [DATA_BITS-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_BITS'(i);
    return m;
  endfunction

  // Power-up content is mem[i] = i; the array is deliberately never reset
  mem_t mem = init_mem();

  ram_state_t                  state_q, state_d;
  logic [RAM_ADDRESS_BITS-1:0] base_q, base_d;
  logic [RAM_ADDRESS_BITS-1:0] served_q, served_d;
  logic                        armed_q, armed_d;
  logic [DATA_BITS-1:0]        data_q [BLOCK_SIZE-1:0];
  logic [DATA_BITS-1:0]        data_d [BLOCK_SIZE-1:0];
  logic [RAM_ADDRESS_BITS-1:0] addr_base;
  logic                        accept, sample, done;

  assign addr_base = address & ~OFF_MASK;

  ram_latency_timer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (accept),
    .dec_i  (state_q == WAIT),
    .done_o (done)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    served_d = served_q;
    armed_d  = armed_q;
    accept   = 1'b0;
    sample   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_en && armed_q) begin
          accept  = 1'b1;
          base_d  = addr_base;
          state_d = WAIT;
        end else if (!armed_q && (!read_en || addr_base != served_q)) begin
          // The cache has let go of (or moved off) the block just served
          armed_d = 1'b1;
        end
      end
      WAIT: begin
        if (done) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        served_d = base_q;
        armed_d  = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing on the sampling edge is forwarded into the response
  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      data_d[k] = data_q[k];
      if (sample) begin
        if (write_en && address == (base_q | RAM_ADDRESS_BITS'(k)))
          data_d[k] = write_data;
        else
          data_d[k] = mem[base_q | RAM_ADDRESS_BITS'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      served_q <= '0;
      armed_q  <= 1'b1;
      for (int k = 0; k < BLOCK_SIZE; k++) data_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      served_q <= served_d;
      armed_q  <= armed_d;
      for (int k = 0; k < BLOCK_SIZE; k++) data_q[k] <= data_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[address] <= write_data;
  end

  assign ram_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign ram_state = state_q;
  assign ram_data  = data_q;

endmodule
